router_fsm: RTL and testbench
=============================

ROUTER_FSM -- requirements
Module: router_fsm

Interface
REQ-001 SHALL have no parameters; address width fixed at 2, port count fixed at 3.
REQ-002 clock  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 pkt_valid  in  1  source asserts for header and payload bytes, deasserts on parity byte.
REQ-005 data_in  in  2  header address bits [1:0]; 0..2 valid, 3 invalid.
REQ-006 fifo_full  in  1  full flag of the currently selected output FIFO.
REQ-007 fifo_empty  in  3  per-port FIFO empty flags, bit n = port n.
REQ-008 soft_reset  in  3  per-port timeout resets, bit n = port n.
REQ-009 parity_done, low_pkt_valid  in  1 each  status from the register block.
REQ-010 detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg  out  1 each  state strobes to the register block.
REQ-011 write_enb_reg  out  1  FIFO write enable; busy  out  1  back-pressure to source; addr_q  out  2  latched destination port.

Function
REQ-012 SHALL implement a Moore FSM with states DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, LOAD_PARITY, FIFO_FULL_STATE, LOAD_AFTER_FULL, WAIT_TILL_EMPTY, CHECK_PARITY_ERROR.
REQ-013 DECODE_ADDRESS: pkt_valid & data_in!=3 & fifo_empty[data_in] -> LOAD_FIRST_DATA; pkt_valid & data_in!=3 & ~fifo_empty[data_in] -> WAIT_TILL_EMPTY; otherwise stay (address 3 discarded).
REQ-014 addr_q SHALL load data_in on the DECODE_ADDRESS exit edge and hold until next exit; other cycles unchanged.
REQ-015 WAIT_TILL_EMPTY: fifo_empty[addr_q] -> LOAD_FIRST_DATA, else stay.
REQ-016 LOAD_FIRST_DATA -> LOAD_DATA unconditionally (exactly one cycle).
REQ-017 LOAD_DATA: fifo_full -> FIFO_FULL_STATE; else ~pkt_valid -> LOAD_PARITY; else stay; fifo_full has priority.
REQ-018 LOAD_PARITY -> CHECK_PARITY_ERROR unconditionally.
REQ-019 CHECK_PARITY_ERROR: fifo_full -> FIFO_FULL_STATE, else DECODE_ADDRESS.
REQ-020 FIFO_FULL_STATE: ~fifo_full -> LOAD_AFTER_FULL, else stay.
REQ-021 LOAD_AFTER_FULL: parity_done -> DECODE_ADDRESS; ~parity_done & low_pkt_valid -> LOAD_PARITY; else LOAD_DATA.
REQ-022 soft_reset[addr_q] high in any state other than DECODE_ADDRESS SHALL force DECODE_ADDRESS next cycle, overriding all other transitions; soft_reset on other ports ignored.
REQ-023 Strobes decoded from current state only: detect_add=DECODE_ADDRESS, lfd_state=LOAD_FIRST_DATA, ld_state=LOAD_DATA, laf_state=LOAD_AFTER_FULL, full_state=FIFO_FULL_STATE, rst_int_reg=CHECK_PARITY_ERROR; exactly one high per cycle, WAIT_TILL_EMPTY/LOAD_PARITY assert none.
REQ-024 write_enb_reg high in LOAD_DATA, LOAD_PARITY, LOAD_AFTER_FULL; low elsewhere.
REQ-025 busy low in DECODE_ADDRESS and LOAD_DATA, high in all other states.
REQ-026 Outputs SHALL be glitch-free decodes of a registered state; no input-to-output combinational path.

Reset
REQ-027 reset high at a clock edge SHALL set state=DECODE_ADDRESS, addr_q=0; outputs then detect_add=1, all other strobes=0, write_enb_reg=0, busy=0.
REQ-028 reset SHALL override soft_reset and all transitions, including mid-packet and in FIFO_FULL_STATE.

Structure
REQ-029 State encodings (3-bit binary) and address width/invalid-address constant SHALL live in shared package router_pkg, used by this block and the router top.
REQ-030 Single flat module; no sub-module.

Verification
REQ-031 Reset, then pkt_valid=1, data_in=1, fifo_empty=3'b111 -> LOAD_FIRST_DATA next cycle, addr_q=1, lfd_state=1, busy=1.
REQ-032 Header to port 2 with fifo_empty=3'b011 -> WAIT_TILL_EMPTY, busy=1, no strobes; set fifo_empty[2]=1 -> LOAD_FIRST_DATA next cycle.
REQ-033 3-byte payload then pkt_valid=0, fifo_full=0 -> LOAD_DATA x3, LOAD_PARITY, CHECK_PARITY_ERROR (rst_int_reg=1), DECODE_ADDRESS.
REQ-034 fifo_full=1 during LOAD_DATA -> FIFO_FULL_STATE, busy=1, write_enb_reg=0; release with low_pkt_valid=1, parity_done=0 -> LOAD_AFTER_FULL then LOAD_PARITY.
REQ-035 In LOAD_DATA with addr_q=0: soft_reset=3'b010 -> no effect; soft_reset=3'b001 -> DECODE_ADDRESS next cycle.
REQ-036 data_in=3 with pkt_valid=1 for 4 cycles -> state stays DECODE_ADDRESS, addr_q unchanged, busy=0.

Source files
------------

// File: rtl/router_pkg.sv
// Shared router definitions: FSM state encodings, address width and port-select helper.
package router_pkg;

    localparam int ADDR_W    = 2;
    localparam int NUM_PORTS = 3;
    localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'd3;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        LOAD_PARITY        = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        WAIT_TILL_EMPTY    = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } state_t;

    // Picks the bit of a per-port vector for a port address; the invalid address selects nothing.
    function automatic logic port_sel(input logic [NUM_PORTS-1:0] vec,
                                      input logic [ADDR_W-1:0]    addr);
        logic bit_out;
        bit_out = 1'b0;
        case (addr)
            2'd0:    bit_out = vec[0];
            2'd1:    bit_out = vec[1];
            2'd2:    bit_out = vec[2];
            default: bit_out = 1'b0;
        endcase
        return bit_out;
    endfunction

endpackage

// File: rtl/router_fsm.sv
// Router packet-control Moore FSM: decodes the header, sequences payload/parity loads into the selected FIFO.
// Outputs decode only the registered state (no input-to-output path); busy throttles the source outside DECODE/LOAD_DATA.
module router_fsm
    import router_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 pkt_valid,
    input  logic [ADDR_W-1:0]    data_in,
    input  logic                 fifo_full,
    input  logic [NUM_PORTS-1:0] fifo_empty,
    input  logic [NUM_PORTS-1:0] soft_reset,
    input  logic                 parity_done,
    input  logic                 low_pkt_valid,
    output logic                 detect_add,
    output logic                 lfd_state,
    output logic                 ld_state,
    output logic                 laf_state,
    output logic                 full_state,
    output logic                 rst_int_reg,
    output logic                 write_enb_reg,
    output logic                 busy,
    output logic [ADDR_W-1:0]    addr_q
);

    state_t state;
    state_t next_state;
    logic   header_ok;

    assign header_ok = pkt_valid && (data_in != ADDR_INVALID);

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= DECODE_ADDRESS;
            addr_q <= '0;
        end else begin
            state <= next_state;
            // Any accepted header leaves DECODE_ADDRESS, so this is exactly the exit edge.
            if (state == DECODE_ADDRESS && header_ok)
                addr_q <= data_in;
        end
    end

    always_comb begin
        next_state    = state;
        detect_add    = 1'b0;
        lfd_state     = 1'b0;
        ld_state      = 1'b0;
        laf_state     = 1'b0;
        full_state    = 1'b0;
        rst_int_reg   = 1'b0;
        write_enb_reg = 1'b0;
        busy          = 1'b1;

        case (state)
            DECODE_ADDRESS: begin
                detect_add = 1'b1;
                busy       = 1'b0;
                if (header_ok)
                    next_state = port_sel(fifo_empty, data_in) ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
            end
            WAIT_TILL_EMPTY: begin
                if (port_sel(fifo_empty, addr_q))
                    next_state = LOAD_FIRST_DATA;
            end
            LOAD_FIRST_DATA: begin
                lfd_state  = 1'b1;
                next_state = LOAD_DATA;
            end
            LOAD_DATA: begin
                ld_state      = 1'b1;
                write_enb_reg = 1'b1;
                busy          = 1'b0;
                if (fifo_full)
                    next_state = FIFO_FULL_STATE;
                else if (!pkt_valid)
                    next_state = LOAD_PARITY;
            end
            LOAD_PARITY: begin
                write_enb_reg = 1'b1;
                next_state    = CHECK_PARITY_ERROR;
            end
            CHECK_PARITY_ERROR: begin
                rst_int_reg = 1'b1;
                next_state  = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            end
            FIFO_FULL_STATE: begin
                full_state = 1'b1;
                if (!fifo_full)
                    next_state = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
                laf_state     = 1'b1;
                write_enb_reg = 1'b1;
                if (parity_done)
                    next_state = DECODE_ADDRESS;
                else if (low_pkt_valid)
                    next_state = LOAD_PARITY;
                else
                    next_state = LOAD_DATA;
            end
            default: next_state = DECODE_ADDRESS;
        endcase

        // A timeout on the port being served abandons the packet from any busy state.
        if (state != DECODE_ADDRESS && port_sel(soft_reset, addr_q))
            next_state = DECODE_ADDRESS;
    end

endmodule

// File: tb/tb_router_fsm.sv
// Directed bench for router_fsm: walks each transition and checks the state-decoded outputs and addr_q.
module tb_router_fsm;
    import router_pkg::*;

    logic       clock = 1'b0;
    logic       reset, pkt_valid, fifo_full, parity_done, low_pkt_valid;
    logic [1:0] data_in;
    logic [2:0] fifo_empty, soft_reset;
    logic       detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg;
    logic       write_enb_reg, busy;
    logic [1:0] addr_q;

    int tests = 0;
    int fails = 0;

    router_fsm dut (
        .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .soft_reset(soft_reset),
        .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
        .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
        .laf_state(laf_state), .full_state(full_state), .rst_int_reg(rst_int_reg),
        .write_enb_reg(write_enb_reg), .busy(busy), .addr_q(addr_q)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Output pattern {detect_add,lfd,ld,laf,full,rst_int,write_enb,busy} required in each state.
    function automatic logic [7:0] exp_out(input state_t s);
        case (s)
            DECODE_ADDRESS:     return 8'b1000_0000;
            LOAD_FIRST_DATA:    return 8'b0100_0001;
            LOAD_DATA:          return 8'b0010_0010;
            LOAD_PARITY:        return 8'b0000_0011;
            FIFO_FULL_STATE:    return 8'b0000_1001;
            LOAD_AFTER_FULL:    return 8'b0001_0011;
            WAIT_TILL_EMPTY:    return 8'b0000_0001;
            default:            return 8'b0000_0101;
        endcase
    endfunction

    task automatic step_chk(input string tag, input state_t s, input logic [1:0] a);
        @(posedge clock);
        #1;
        check({tag, "_outs"}, {24'd0, detect_add, lfd_state, ld_state, laf_state, full_state,
                               rst_int_reg, write_enb_reg, busy}, {24'd0, exp_out(s)});
        check({tag, "_addr"}, {30'd0, addr_q}, {30'd0, a});
    endtask

    initial begin
        reset = 1'b1; pkt_valid = 1'b0; data_in = 2'd0; fifo_full = 1'b0;
        fifo_empty = 3'b111; soft_reset = 3'b000; parity_done = 1'b0; low_pkt_valid = 1'b0;
        step_chk("reset", DECODE_ADDRESS, 2'd0);
        reset = 1'b0;
        step_chk("idle", DECODE_ADDRESS, 2'd0);

        // Header to empty port 1, three payload bytes, parity.
        pkt_valid = 1'b1; data_in = 2'd1;
        step_chk("hdr_p1", LOAD_FIRST_DATA, 2'd1);
        data_in = 2'd0;
        step_chk("ld1", LOAD_DATA, 2'd1);
        step_chk("ld2", LOAD_DATA, 2'd1);
        step_chk("ld3", LOAD_DATA, 2'd1);
        pkt_valid = 1'b0;
        step_chk("parity", LOAD_PARITY, 2'd1);
        step_chk("chk_par", CHECK_PARITY_ERROR, 2'd1);
        step_chk("back_dec", DECODE_ADDRESS, 2'd1);

        // Port 2 busy: wait, then proceed once its FIFO drains.
        pkt_valid = 1'b1; data_in = 2'd2; fifo_empty = 3'b011;
        step_chk("wait1", WAIT_TILL_EMPTY, 2'd2);
        step_chk("wait2", WAIT_TILL_EMPTY, 2'd2);
        fifo_empty = 3'b111;
        step_chk("wait_lfd", LOAD_FIRST_DATA, 2'd2);
        step_chk("p2_ld", LOAD_DATA, 2'd2);
        fifo_full = 1'b1;
        step_chk("full1", FIFO_FULL_STATE, 2'd2);
        step_chk("full2", FIFO_FULL_STATE, 2'd2);
        fifo_full = 1'b0; low_pkt_valid = 1'b1;
        step_chk("laf_low", LOAD_AFTER_FULL, 2'd2);
        step_chk("laf_par", LOAD_PARITY, 2'd2);
        low_pkt_valid = 1'b0; pkt_valid = 1'b0; fifo_full = 1'b1;
        step_chk("cpe_full", CHECK_PARITY_ERROR, 2'd2);
        step_chk("cpe_to_full", FIFO_FULL_STATE, 2'd2);
        // Reset beats soft_reset and the full stall.
        reset = 1'b1; soft_reset = 3'b111;
        step_chk("rst_full", DECODE_ADDRESS, 2'd0);
        reset = 1'b0; soft_reset = 3'b000; fifo_full = 1'b0;

        // Port 0: soft_reset on other port ignored, own port aborts.
        pkt_valid = 1'b1; data_in = 2'd0;
        step_chk("p0_lfd", LOAD_FIRST_DATA, 2'd0);
        step_chk("p0_ld", LOAD_DATA, 2'd0);
        soft_reset = 3'b010;
        step_chk("sr_other", LOAD_DATA, 2'd0);
        soft_reset = 3'b001;
        step_chk("sr_own", DECODE_ADDRESS, 2'd0);
        soft_reset = 3'b000;

        // fifo_full wins over end of packet; LAF fall-back and parity_done exits.
        step_chk("p0b_lfd", LOAD_FIRST_DATA, 2'd0);
        step_chk("p0b_ld", LOAD_DATA, 2'd0);
        pkt_valid = 1'b0; fifo_full = 1'b1;
        step_chk("full_prio", FIFO_FULL_STATE, 2'd0);
        fifo_full = 1'b0;
        step_chk("laf_a", LOAD_AFTER_FULL, 2'd0);
        pkt_valid = 1'b1;
        step_chk("laf_to_ld", LOAD_DATA, 2'd0);
        fifo_full = 1'b1;
        step_chk("full_b", FIFO_FULL_STATE, 2'd0);
        fifo_full = 1'b0; parity_done = 1'b1; low_pkt_valid = 1'b1;
        step_chk("laf_b", LOAD_AFTER_FULL, 2'd0);
        pkt_valid = 1'b0;
        step_chk("laf_done", DECODE_ADDRESS, 2'd0);
        parity_done = 1'b0; low_pkt_valid = 1'b0;

        // Soft reset while waiting on port 1.
        pkt_valid = 1'b1; data_in = 2'd1; fifo_empty = 3'b000;
        step_chk("w_p1", WAIT_TILL_EMPTY, 2'd1);
        soft_reset = 3'b100;
        step_chk("w_sr_other", WAIT_TILL_EMPTY, 2'd1);
        soft_reset = 3'b010;
        step_chk("w_sr_own", DECODE_ADDRESS, 2'd1);
        soft_reset = 3'b000; fifo_empty = 3'b111;

        // Invalid address 3 is discarded.
        data_in = 2'd3;
        for (int i = 0; i < 4; i++)
            step_chk("addr3", DECODE_ADDRESS, 2'd1);

        // Reset mid-packet.
        data_in = 2'd2;
        step_chk("p2b_lfd", LOAD_FIRST_DATA, 2'd2);
        step_chk("p2b_ld", LOAD_DATA, 2'd2);
        reset = 1'b1;
        step_chk("rst_mid", DECODE_ADDRESS, 2'd0);
        reset = 1'b0; pkt_valid = 1'b0;
        step_chk("final_idle", DECODE_ADDRESS, 2'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
